// File: rtl/lfsr_cipher_pkg.sv
// ============================================================================
// lfsr_cipher_pkg : shared FSM encoding and default tap masks for lfsr_cipher_n
// Revision 1.0
// ============================================================================
`default_nettype none

package lfsr_cipher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fsm_e;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;

endpackage

`default_nettype wire

// File: rtl/lfsr_cipher_n_core.sv
// ============================================================================
// lfsr_core : Fibonacci LFSR state with seed load and STEPS-shift advance
// Revision 1.0
// ============================================================================
`default_nettype none

module lfsr_core #(
  parameter int LFSR_W = 16,
  parameter int STEPS  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_value,
  input  logic              advance,
  input  logic [LFSR_W-1:0] tap_mask,
  output logic [DATA_W-1:0] ks_word
);

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] w_chain [0:STEPS];

  assign w_chain[0] = r_state;

  // Unrolled shift chain so several steps complete in one accepted word.
  for (genvar s = 0; s < STEPS; s++) begin : g_step
    assign w_chain[s+1] = {w_chain[s][LFSR_W-2:0], ^(w_chain[s] & tap_mask)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
    end else if (load) begin
      r_state <= load_value;
    end else if (advance) begin
      r_state <= w_chain[STEPS];
    end
  end

  assign ks_word = r_state[DATA_W-1:0];

endmodule

`default_nettype wire

// File: rtl/lfsr_cipher_n.sv
// ============================================================================
// lfsr_cipher_n : valid/ready LFSR stream cipher with optional bounded messages
// Revision 1.0
// ============================================================================
`default_nettype none

module lfsr_cipher_n
  import lfsr_cipher_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LFSR_W = 16,
  parameter int STEPS  = 1,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] key,
  input  logic [LFSR_W-1:0] tap_mask,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  fsm_e              r_fsm;
  fsm_e              w_fsm_nxt;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic [LEN_W-1:0]  r_count;
  logic [LFSR_W-1:0] r_taps;
  logic [LEN_W-1:0]  r_len;

  logic              w_start;
  logic              w_in_ready;
  logic              w_xfer;
  logic              w_last_word;
  logic [DATA_W-1:0] w_ks;
  logic [LFSR_W-1:0] w_seed;

  // The start cycle never accepts, so a start in RUN cannot swallow a word.
  assign w_start     = start & ~stop;
  assign w_in_ready  = (r_fsm == RUN) & (~r_valid | out_ready) & ~stop & ~start;
  assign w_xfer      = in_valid & w_in_ready;
  assign w_last_word = (r_len != '0) && (r_count == r_len - LEN_W'(1));
  assign w_seed      = (key == '0) ? LFSR_W'(1) : key;

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .STEPS  (STEPS),
    .DATA_W (DATA_W)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (w_start),
    .load_value (w_seed),
    .advance    (w_xfer),
    .tap_mask   (r_taps),
    .ks_word    (w_ks)
  );

  always_ff @(posedge clk) begin
    if (reset) r_fsm <= IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    if (stop) begin
      w_fsm_nxt = IDLE;
    end else if (start) begin
      w_fsm_nxt = RUN;
    end else begin
      case (r_fsm)
        IDLE:    w_fsm_nxt = IDLE;
        RUN:     if (w_xfer && w_last_word) w_fsm_nxt = DRAIN;
        DRAIN:   if (r_valid && out_ready)  w_fsm_nxt = IDLE;
        default: w_fsm_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_count <= '0;
      r_taps  <= '0;
      r_len   <= '0;
    end else if (stop) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (start) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_count <= '0;
      r_taps  <= tap_mask;
      r_len   <= msg_len;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= in_data ^ w_ks;
      r_last  <= w_last_word;
      r_count <= r_count + LEN_W'(1);
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_data;
  assign out_valid = r_valid & ~stop;
  assign out_last  = r_last;
  assign busy      = (r_fsm != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_lfsr_cipher_n.sv
// ============================================================================
// tb_lfsr_cipher_n : scoreboard bench for lfsr_cipher_n (8-bit KAT + 16-bit loopback)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_lfsr_cipher_n;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8-bit instance
  logic [7:0]  key, tap_mask, in_data, out_data;
  logic [15:0] msg_len;
  logic        start, stop, in_valid, in_ready, out_valid, out_ready, out_last, busy;

  // 16-bit encryptor/decryptor pair
  logic [15:0] lb_key, lb_taps, lb_len;
  logic        lb_start, lb_stop;
  logic [7:0]  enc_in_data, c_data, p_data;
  logic        enc_in_valid, enc_in_ready, c_valid, dec_in_ready;
  logic        enc_last, enc_busy, p_valid, dec_out_ready, dec_last, dec_busy;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t       sb8[$];
  logic [7:0] q_enc[$];
  logic [7:0] q_dec[$];

  lfsr_cipher_n #(.DATA_W(8), .LFSR_W(8), .STEPS(1), .LEN_W(16)) u_dut (
    .clk(clk), .reset(reset), .key(key), .tap_mask(tap_mask), .msg_len(msg_len),
    .start(start), .stop(stop), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy));

  lfsr_cipher_n #(.DATA_W(8), .LFSR_W(16), .STEPS(1), .LEN_W(16)) u_enc (
    .clk(clk), .reset(reset), .key(lb_key), .tap_mask(lb_taps), .msg_len(lb_len),
    .start(lb_start), .stop(lb_stop), .in_data(enc_in_data), .in_valid(enc_in_valid),
    .in_ready(enc_in_ready), .out_data(c_data), .out_valid(c_valid),
    .out_ready(dec_in_ready), .out_last(enc_last), .busy(enc_busy));

  lfsr_cipher_n #(.DATA_W(8), .LFSR_W(16), .STEPS(1), .LEN_W(16)) u_dec (
    .clk(clk), .reset(reset), .key(lb_key), .tap_mask(lb_taps), .msg_len(lb_len),
    .start(lb_start), .stop(lb_stop), .in_data(c_data), .in_valid(c_valid),
    .in_ready(dec_in_ready), .out_data(p_data), .out_valid(p_valid),
    .out_ready(dec_out_ready), .out_last(dec_last), .busy(dec_busy));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop the oldest expectation whenever a word is handed off.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      n_checks++;
      if (sb8.size() == 0) begin
        n_fail++;
        $display("FAIL sb8 unexpected word: got %0h expected none", out_data);
      end else begin
        exp_t e;
        e = sb8.pop_front();
        if (out_data !== e.data || out_last !== e.last) begin
          n_fail++;
          $display("FAIL sb8 word: got data %0h last %0b expected data %0h last %0b",
                   out_data, out_last, e.data, e.last);
        end
      end
    end
    if (c_valid && dec_in_ready) begin
      n_checks++;
      if (q_enc.size() == 0) begin
        n_fail++;
        $display("FAIL cipher unexpected word: got %0h expected none", c_data);
      end else begin
        logic [7:0] pt;
        pt = q_enc.pop_front();
        if (c_data === pt) begin
          n_fail++;
          $display("FAIL cipher equals plain: got %0h required not %0h", c_data, pt);
        end
      end
    end
    if (p_valid && dec_out_ready) begin
      n_checks++;
      if (q_dec.size() == 0) begin
        n_fail++;
        $display("FAIL loopback unexpected word: got %0h expected none", p_data);
      end else begin
        logic [7:0] pt;
        pt = q_dec.pop_front();
        if (p_data !== pt) begin
          n_fail++;
          $display("FAIL loopback plain: got %0h expected %0h", p_data, pt);
        end
      end
    end
  end

  task automatic do_start(input logic [7:0] k, input logic [15:0] len);
    key = k; tap_mask = 8'hB8; msg_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send8(input logic [7:0] d, input logic [7:0] exp_d, input logic exp_l);
    int n;
    in_valid = 1'b1; in_data = d;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin tick(); #1; n++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send8 timeout: got in_ready 0 expected 1");
    end else begin
      sb8.push_back('{last: exp_l, data: exp_d});
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb8.size() != 0 || q_dec.size() != 0) && n < 40) begin tick(); n++; end
    check("drained", sb8.size() + q_dec.size(), 0);
  endtask

  task automatic known_answer();
    do_start(8'h95, 16'd0);
    send8(8'h61, 8'hF4, 1'b0);
    check("kat latency valid", out_valid, 1);
    check("kat latency data", out_data, 8'hF4);
    send8(8'h62, 8'h48, 1'b0);
    send8(8'h63, 8'h37, 1'b0);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    key = '0; tap_mask = '0; msg_len = '0; start = 1'b0; stop = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    lb_key = 16'hACE1; lb_taps = 16'hB400; lb_len = '0; lb_start = 1'b0; lb_stop = 1'b0;
    enc_in_data = '0; enc_in_valid = 1'b0; dec_out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 0);
    check("reset out_last", out_last, 0);

    // Known answer
    known_answer();

    // Backpressure mid-stream
    do_start(8'h95, 16'd0);
    send8(8'h61, 8'hF4, 1'b0);
    send8(8'h62, 8'h48, 1'b0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h63;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp in_ready", in_ready, 0);
      check("bp out_data held", out_data, 8'h48);
      check("bp out_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    send8(8'h63, 8'h37, 1'b0);
    send8(8'h64, 8'hCD, 1'b0);
    send8(8'h65, 8'h36, 1'b0);
    wait_drain();

    // Bounded message of three words
    do_start(8'h95, 16'd3);
    send8(8'h61, 8'hF4, 1'b0);
    send8(8'h62, 8'h48, 1'b0);
    send8(8'h63, 8'h37, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("drain out_last", out_last, 1);
      check("drain busy", busy, 1);
      check("drain in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("post drain busy", busy, 0);
    check("post drain in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 8'h64;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle ignores in_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    wait_drain();

    // Stop on the fourth word
    do_start(8'h95, 16'd0);
    send8(8'h61, 8'hF4, 1'b0);
    send8(8'h62, 8'h48, 1'b0);
    send8(8'h63, 8'h37, 1'b0);
    in_valid = 1'b1; in_data = 8'h64;
    #1;
    check("stop word4 ready", in_ready, 1);
    tick();
    in_valid = 1'b0; stop = 1'b1;
    #1;
    check("stop out_valid same cycle", out_valid, 0);
    check("stop in_ready", in_ready, 0);
    tick();
    stop = 1'b0;
    #1;
    check("stop busy", busy, 0);
    check("stop out_data cleared", out_data, 0);

    // Start and stop together from RUN
    do_start(8'h95, 16'd0);
    check("run busy", busy, 1);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start+stop busy", busy, 0);
    check("start+stop in_ready", in_ready, 0);

    // Zero key falls back to seed 1
    do_start(8'h00, 16'd0);
    send8(8'h00, 8'h01, 1'b0);
    wait_drain();

    // Reset mid-RUN with a held word
    do_start(8'h95, 16'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h61;
    #1;
    check("pre-reset in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("pre-reset out_valid", out_valid, 1);
    check("pre-reset out_data", out_data, 8'hF4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid reset out_valid", out_valid, 0);
    check("mid reset out_data", out_data, 0);
    check("mid reset out_last", out_last, 0);
    check("mid reset busy", busy, 0);
    check("mid reset in_ready", in_ready, 0);
    out_ready = 1'b1;
    known_answer();

    // Encryptor/decryptor loopback
    lb_start = 1'b1;
    tick();
    lb_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int n;
      enc_in_valid = 1'b1; enc_in_data = 8'h61 + 8'(i);
      #1;
      n = 0;
      while (!enc_in_ready && n < 20) begin tick(); #1; n++; end
      if (!enc_in_ready) begin
        n_checks++; n_fail++;
        $display("FAIL loopback send timeout: got in_ready 0 expected 1");
      end else begin
        q_enc.push_back(enc_in_data);
        q_dec.push_back(enc_in_data);
      end
      tick();
    end
    enc_in_valid = 1'b0;
    wait_drain();
    check("cipher queue empty", q_enc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
